uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial-to-byte receiver that consumes the UART line carried by the board-level UART bridge: either the `RsRx` pin or the JB input that the bridge forwards to `RsTx`. It synchronises the asynchronous line and recovers 8N1 frames by 16x oversampling. Received bytes are buffered in a small FIFO and presented on a valid/ready byte interface to downstream logic.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate; oversample divisor `DIV = CLK_HZ / (16*BAUD)` (integer division, must be >= 2).
- `FIFO_DEPTH`, 4, byte entries; power of two, >= 2.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line, idle high.
- `data`  out  8  head-of-FIFO byte; valid only while `valid`=1.
- `valid`  out  1  FIFO not empty.
- `ready`  in  1  consumer accepts `data` when `valid`&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped, FIFO full.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- `rx` passes a 2-flop synchroniser (`rx_s`); both flops reset to 1.
- Tick counter counts 0..DIV-1 and emits a one-cycle `tick` at DIV-1. It is held at 0 in IDLE and starts counting on the cycle the FSM leaves IDLE.
- 4-bit sample counter advances on each `tick`. 3-bit bit index.
- FSM states:
  - IDLE: `rx_s`=0 -> START, clear counters.
  - START: at 8th tick, `rx_s`=0 -> DATA (clear sample counter), else -> IDLE (glitch rejected, nothing reported).
  - DATA: every 16th tick, sample `rx_s` into shift register LSB first. After bit 7 -> STOP.
  - STOP: at 16th tick, sample `rx_s`.
    - If 1: push the byte -> IDLE.
    - If 0: pulse `frame_err`, discard the byte -> BREAK.
  - BREAK: wait for `rx_s`=1 -> IDLE. No start detection while low.
- Push rule:
  - FIFO not full: byte is written.
  - FIFO full with a pop in the same cycle: push accepted, no overrun.
  - FIFO full with no pop: byte dropped and `overrun` pulses.
- Pop when `valid`&`ready`; `data` updates to the next entry on the following cycle.
- FIFO storage:
  - Circular buffer with read/write pointers of `log2(FIFO_DEPTH)` bits, wrapping modulo depth.
  - Occupancy counter 0..FIFO_DEPTH.
  - `valid` = count!=0.
- `busy` = 1 in START/DATA/STOP/BREAK.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. FSM is in IDLE, FIFO is empty, synchroniser holds 1.
- Reset mid-frame abandons the frame; no pulse and no push result from it.
- Reset during a pending `valid` flushes the FIFO.
- Line-to-FSM latency: 2 clk (synchroniser), then 1 clk to enter START.
- Sample points, counted from START entry:
  - start bit check at 8 ticks;
  - data bit i at 8+16*(i+1) ticks;
  - stop bit at 152 ticks.
- `valid` rises 1 clk after the stop-sample cycle when the FIFO was empty. `frame_err` and `overrun` assert on that same cycle, for exactly 1 clk.
- After a good stop sample the FSM is in IDLE at tick 152, roughly mid stop bit. A start edge arriving immediately after the stop bit (zero idle gap) is therefore detected.
- The handshake has no combinational path from `ready` to `valid`.
- `data` is stable while `valid`=1 and `ready`=0.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD=10_000 (DIV=10, 160 clk/bit).
- Frame 0xA5 with good stop, `ready`=0 -> `valid`=1 and `data`=0xA5 held until `ready` pulses; then `valid`=0 next cycle, `frame_err`=`overrun`=0 throughout.
- `rx` low for 40 clk then high -> FSM returns to IDLE, `busy` drops, `valid` stays 0, no pulses.
- Frame 0x3C with stop=0, line then held low 320 clk -> one-cycle `frame_err`, no `valid`, `busy`=1 until line high. A following 0x81 frame is received correctly.
- Frames 0x01..0x05 back-to-back, `ready`=0 -> `overrun` pulses once, on the 5th frame. Draining yields 0x01, 0x02, 0x03, 0x04, then `valid`=0.
- Frames 0xFF then 0x00 with zero idle gap, `ready`=1 -> both bytes delivered in order, no errors.
- `reset` pulsed for 1 clk during bit 3 of 0x5A -> all outputs return to reset values next cycle. A subsequent 0xC3 frame delivers `data`=0xC3.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a small byte FIFO
// that is presented on a valid/ready byte interface.
module uart_rx_fifo #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned DIV = CLK_HZ / (16 * BAUD);
   localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t        state, state_n;
   logic          rx_m, rx_s;
   logic [TW-1:0] tick_cnt, tick_cnt_n;
   logic [3:0]    samp_cnt, samp_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          tick_c, stop_ok_c, ferr_c;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
   logic [CW-1:0] count, count_n;
   logic          pop_c, full_c, wr_c, ovr_c;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign tick_c = (state != IDLE) && (tick_cnt == TICK_LAST);

   // Receiver state and oversampling counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_cnt_n;
         samp_cnt <= samp_cnt_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
      end
   end

   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      samp_cnt_n = samp_cnt;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      stop_ok_c  = 1'b0;
      ferr_c     = 1'b0;

      if (state == IDLE || tick_c) tick_cnt_n = '0;
      else                         tick_cnt_n = tick_cnt + TW'(1);
      if (tick_c) samp_cnt_n = samp_cnt + 4'd1;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n    = START;
               samp_cnt_n = '0;
               bit_idx_n  = '0;
            end
         end
         START: begin
            // Mid start bit: confirm it is still low, else treat as a glitch.
            if (tick_c && samp_cnt == 4'd7) begin
               if (!rx_s) begin
                  state_n    = DATA;
                  samp_cnt_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (tick_c && samp_cnt == 4'd15) begin
               shift_n   = {rx_s, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (tick_c && samp_cnt == 4'd15) begin
               if (rx_s) begin
                  state_n   = IDLE;
                  stop_ok_c = 1'b1;
               end else begin
                  state_n = BRK;
                  ferr_c  = 1'b1;
               end
            end
         end
         BRK: begin
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // FIFO push/pop decisions; a full FIFO still accepts a byte when popping.
   always_comb begin
      pop_c    = valid && ready;
      full_c   = (count == CW'(FIFO_DEPTH));
      wr_c     = stop_ok_c && (!full_c || pop_c);
      ovr_c    = stop_ok_c && full_c && !pop_c;
      rd_ptr_n = pop_c ? rd_ptr + AW'(1) : rd_ptr;
      count_n  = count + CW'(wr_c) - CW'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (wr_c) mem[wr_ptr] <= shift;
   end

   // Registered outputs; data tracks the head entry of the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rd_ptr    <= rd_ptr_n;
         if (wr_c) wr_ptr <= wr_ptr + AW'(1);
         count     <= count_n;
         data      <= (wr_c && (wr_ptr == rd_ptr_n)) ? shift : mem[rd_ptr_n];
         valid     <= (count_n != '0);
         frame_err <= ferr_c;
         overrun   <= ovr_c;
         busy      <= (state_n != IDLE);
      end
   end

endmodule
